// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared definitions for the iterative divider used by the execute stage.
//   - div_state_e   : divider FSM state codes (2 bits)
//   - DivResultReady / DivResultNotReady : ready_o levels
//   - DivStart / DivStop                  : start_i levels
//   - DoubleRegBus  : width of the {Hi, Lo} result bus
// ---------------------------------------------------------------------------
package div_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam logic DivStart = 1'b1;
  localparam logic DivStop  = 1'b0;

  localparam int DoubleRegBus = 64;

endpackage : div_pkg

// File: rtl/div.sv
// ---------------------------------------------------------------------------
// div
// Iterative radix-2 restoring divider for div/divu. One quotient bit is
// produced per clock; a non-zero-divisor division completes 33 edges after
// it is accepted, a zero divisor completes after 2 edges with an all-zero
// result. Only one division is in flight at a time.
//
// Ports
//   clk          : clock
//   rst          : asynchronous reset, active low
//   signed_div_i : 1 = signed (div), 0 = unsigned (divu); sampled at accept
//   opdata1_i    : dividend; sampled at accept
//   opdata2_i    : divisor; sampled at accept
//   start_i      : request, held high by the execute stage until ready_o
//   annul_i      : flush, aborts any in-flight division
//   result_o     : {remainder (Hi), quotient (Lo)}, held until next accept
//   ready_o      : single-cycle pulse marking result_o valid
// ---------------------------------------------------------------------------
module div
  import div_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam logic [DATA_W-1:0] ONE      = DATA_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

  // Two's-complement negation.
  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
    return ~v + ONE;
  endfunction

  div_state_e          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_rem;     // partial remainder
  logic [DATA_W-1:0]   r_dvd;     // dividend, shifts out MSB-first, quotient shifts in
  logic [DATA_W-1:0]   r_dvs;     // |divisor|
  logic                r_neg1;    // dividend was negative (signed only)
  logic                r_neg2;    // divisor was negative (signed only)
  logic                r_signed;

  logic [DATA_W-1:0]   w_abs1;
  logic [DATA_W-1:0]   w_abs2;
  logic [DATA_W:0]     w_rem_sh;
  logic [DATA_W:0]     w_trial;
  logic                w_qbit;
  logic [DATA_W-1:0]   w_rem_next;
  logic [DATA_W-1:0]   w_quo_next;
  logic [DATA_W-1:0]   w_quo_fix;
  logic [DATA_W-1:0]   w_rem_fix;
  logic                w_abort;
  logic                w_accept;

  // Magnitudes at accept; unsigned operands pass through untouched.
  assign w_abs1 = (signed_div_i && opdata1_i[DATA_W-1]) ? negate(opdata1_i) : opdata1_i;
  assign w_abs2 = (signed_div_i && opdata2_i[DATA_W-1]) ? negate(opdata2_i) : opdata2_i;

  // One restoring step. The shifted remainder is below 2*divisor, so a
  // DATA_W+1 bit difference is enough: its MSB is set exactly when the
  // subtraction would go negative.
  assign w_rem_sh   = {r_rem, r_dvd[DATA_W-1]};
  assign w_trial    = w_rem_sh - {1'b0, r_dvs};
  assign w_qbit     = ~w_trial[DATA_W];
  assign w_rem_next = w_qbit ? w_trial[DATA_W-1:0] : w_rem_sh[DATA_W-1:0];
  assign w_quo_next = {r_dvd[DATA_W-2:0], w_qbit};

  // Quotient is negative when operand signs differ; remainder follows the
  // dividend's sign. INT_MIN / -1 wraps back to INT_MIN naturally.
  assign w_quo_fix = (r_signed && (r_neg1 ^ r_neg2)) ? negate(w_quo_next) : w_quo_next;
  assign w_rem_fix = (r_signed && r_neg1) ? negate(w_rem_next) : w_rem_next;

  assign w_abort  = annul_i || (start_i == DivStop);
  assign w_accept = (start_i == DivStart) && !annul_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= DivFree;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_neg1   <= 1'b0;
      r_neg2   <= 1'b0;
      r_signed <= 1'b0;
      result_o <= '0;
      ready_o  <= DivResultNotReady;
    end else begin
      case (r_state)
        DivFree: begin
          ready_o <= DivResultNotReady;
          if (w_accept) begin
            if (opdata2_i == '0) begin
              r_state <= DivByZero;
            end else begin
              r_state  <= DivOn;
              r_cnt    <= '0;
              r_rem    <= '0;
              r_dvd    <= w_abs1;
              r_dvs    <= w_abs2;
              r_neg1   <= signed_div_i & opdata1_i[DATA_W-1];
              r_neg2   <= signed_div_i & opdata2_i[DATA_W-1];
              r_signed <= signed_div_i;
            end
          end
        end

        DivByZero: begin
          if (w_abort) begin
            r_state <= DivFree;
          end else begin
            r_state  <= DivEnd;
            result_o <= '0;
            ready_o  <= DivResultReady;
          end
        end

        DivOn: begin
          if (w_abort) begin
            r_state <= DivFree;
          end else begin
            r_rem <= w_rem_next;
            r_dvd <= w_quo_next;
            r_cnt <= r_cnt + CNT_ONE;
            if (r_cnt == CNT_LAST) begin
              r_state  <= DivEnd;
              result_o <= {w_rem_fix, w_quo_fix};
              ready_o  <= DivResultReady;
            end
          end
        end

        DivEnd: begin
          // Always drop ready here so a following request never sees it stale.
          r_state <= DivFree;
          ready_o <= DivResultNotReady;
        end

        default: begin
          r_state <= DivFree;
          ready_o <= DivResultNotReady;
        end
      endcase
    end
  end

endmodule : div

// File: tb/tb_div.sv
module tb_div;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;

  logic                clk;
  logic                rst;
  logic                signed_div_i;
  logic [DATA_W-1:0]   opdata1_i;
  logic [DATA_W-1:0]   opdata2_i;
  logic                start_i;
  logic                annul_i;
  logic [2*DATA_W-1:0] result_o;
  logic                ready_o;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] sb[$];

  div #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (n_vec=%0d)", n_vec);
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ua, ub, q, r;
    if (b == 32'd0) return 64'd0;
    ua = (s && a[31]) ? (~a + 32'd1) : a;
    ub = (s && b[31]) ? (~b + 32'd1) : b;
    q  = ua / ub;
    r  = ua % ub;
    if (s && (a[31] ^ b[31])) q = ~q + 32'd1;
    if (s && a[31])           r = ~r + 32'd1;
    return {r, q};
  endfunction

  // Drives one request and holds start until ready_o (bounded); returns
  // the observed result, edges from accept to ready, and a timeout flag.
  task automatic run_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] res, output int lat, output bit tmo);
    @(negedge clk);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    lat = 0;
    while (1) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (ready_o === 1'b1 || lat >= 100) break;
    end
    tmo = (ready_o !== 1'b1);
    res = result_o;
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    #1 rst = 1'b0;
    #1;
    n_vec++;
    if (ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", ready_o); end
    n_vec++;
    if (result_o !== 64'd0) begin n_err++; $display("FAIL reset_result: got %h want 0", result_o); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (ready_o !== 1'b0) begin n_err++; $display("FAIL idle_ready: got %b want 0", ready_o); end
  endtask

  task automatic test_known();
    typedef struct packed { bit s; logic [31:0] a; logic [31:0] b; logic [63:0] e; } vec_t;
    vec_t tv[5];
    logic [63:0] res, exp;
    int lat;
    bit tmo;
    tv[0] = '{s:1'b0, a:32'd100,       b:32'd7,          e:64'h00000002_0000000E};
    tv[1] = '{s:1'b1, a:32'hFFFFFFF9,  b:32'h2,          e:64'hFFFFFFFF_FFFFFFFD};
    tv[2] = '{s:1'b1, a:32'h7,         b:32'hFFFFFFFE,   e:64'h00000001_FFFFFFFD};
    tv[3] = '{s:1'b0, a:32'hFFFFFFFF,  b:32'h1,          e:64'h00000000_FFFFFFFF};
    tv[4] = '{s:1'b1, a:32'h80000000,  b:32'hFFFFFFFF,   e:64'h00000000_80000000};
    for (int i = 0; i < 5; i++) begin
      sb.push_back(tv[i].e);
      run_div(tv[i].s, tv[i].a, tv[i].b, res, lat, tmo);
      exp = sb.pop_front();
      n_vec++;
      if (tmo || res !== exp) begin
        n_err++; $display("FAIL known_%0d: got %h (timeout=%0d) want %h", i, res, tmo, exp);
      end
      n_vec++;
      if (lat !== 33) begin n_err++; $display("FAIL known_lat_%0d: got %0d want 33", i, lat); end
      @(negedge clk);
      n_vec++;
      if (ready_o !== 1'b0) begin n_err++; $display("FAIL known_pulse_%0d: ready %b want 0", i, ready_o); end
    end
  endtask

  task automatic test_random();
    logic [63:0] res, exp;
    logic [31:0] a, b;
    bit s;
    int lat;
    bit tmo;
    for (int i = 0; i < 12; i++) begin
      s = i[0];
      a = $urandom;
      b = (i % 3 == 0) ? $urandom : $urandom_range(1, 1000);
      if (i % 4 == 1) b = -b;
      if (b == 32'd0) b = 32'd3;
      sb.push_back(model(s, a, b));
      run_div(s, a, b, res, lat, tmo);
      exp = sb.pop_front();
      n_vec++;
      if (tmo || res !== exp || lat !== 33) begin
        n_err++;
        $display("FAIL rand_%0d: s=%0d %h/%h got %h lat %0d want %h lat 33", i, s, a, b, res, lat, exp);
      end
    end
  endtask

  task automatic test_zero();
    logic [63:0] res, exp;
    int lat;
    bit tmo;
    sb.push_back(64'd0);
    run_div(1'b0, 32'd1234, 32'd0, res, lat, tmo);
    exp = sb.pop_front();
    n_vec++;
    if (tmo || res !== exp) begin n_err++; $display("FAIL zero_res: got %h want %h", res, exp); end
    n_vec++;
    if (lat !== 2) begin n_err++; $display("FAIL zero_lat: got %0d want 2", lat); end
    @(negedge clk);
    n_vec++;
    if (ready_o !== 1'b0) begin n_err++; $display("FAIL zero_pulse: ready %b want 0", ready_o); end
    sb.push_back(64'd0);
    run_div(1'b1, 32'h80000000, 32'd0, res, lat, tmo);
    exp = sb.pop_front();
    n_vec++;
    if (tmo || res !== exp || lat !== 2) begin
      n_err++; $display("FAIL zero_signed: got %h lat %0d want %h lat 2", res, lat, exp);
    end
  endtask

  task automatic test_abort();
    logic [63:0] res, exp, prev;
    int lat, seen;
    bit tmo;
    sb.push_back(model(1'b0, 32'd1000, 32'd3));
    run_div(1'b0, 32'd1000, 32'd3, res, lat, tmo);
    exp = sb.pop_front();
    n_vec++;
    if (tmo || res !== exp) begin n_err++; $display("FAIL abort_setup: got %h want %h", res, exp); end
    prev = exp;
    // annul at iteration 10
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'hDEADBEEF; opdata2_i = 32'h123; start_i = 1'b1;
    seen = 0;
    repeat (11) begin @(negedge clk); if (ready_o === 1'b1) seen++; end
    annul_i = 1'b1; start_i = 1'b0;
    @(negedge clk); if (ready_o === 1'b1) seen++;
    annul_i = 1'b0;
    repeat (2) begin @(negedge clk); if (ready_o === 1'b1) seen++; end
    n_vec++;
    if (seen !== 0) begin n_err++; $display("FAIL annul_ready: %0d pulses want 0", seen); end
    n_vec++;
    if (result_o !== prev) begin n_err++; $display("FAIL annul_hold: got %h want %h", result_o, prev); end
    sb.push_back(model(1'b1, 32'hFFFF0000, 32'd77));
    run_div(1'b1, 32'hFFFF0000, 32'd77, res, lat, tmo);
    exp = sb.pop_front();
    n_vec++;
    if (tmo || res !== exp || lat !== 33) begin
      n_err++; $display("FAIL annul_restart: got %h lat %0d want %h lat 33", res, lat, exp);
    end
    // start dropped mid-division
    prev = exp;
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd999; opdata2_i = 32'd5; start_i = 1'b1;
    repeat (5) @(negedge clk);
    start_i = 1'b0;
    seen = 0;
    repeat (40) begin @(negedge clk); if (ready_o === 1'b1) seen++; end
    n_vec++;
    if (seen !== 0 || result_o !== prev) begin
      n_err++; $display("FAIL stop_abort: %0d pulses result %h want 0 pulses result %h", seen, result_o, prev);
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] res, exp;
    int lat;
    bit tmo;
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd5000; opdata2_i = 32'd9; start_i = 1'b1;
    repeat (15) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if (ready_o !== 1'b0) begin n_err++; $display("FAIL areset_ready: got %b want 0", ready_o); end
    n_vec++;
    if (result_o !== 64'd0) begin n_err++; $display("FAIL areset_result: got %h want 0", result_o); end
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    sb.push_back(model(1'b0, 32'd5000, 32'd9));
    run_div(1'b0, 32'd5000, 32'd9, res, lat, tmo);
    exp = sb.pop_front();
    n_vec++;
    if (tmo || res !== exp || lat !== 33) begin
      n_err++; $display("FAIL areset_recover: got %h lat %0d want %h lat 33", res, lat, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp;
    int lat1, lat2;
    sb.push_back(64'h00000002_0000000E);
    sb.push_back(64'hFFFFFFFE_FFFFFFF2);
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    lat1 = 0;
    while (1) begin
      @(posedge clk); lat1++; @(negedge clk);
      if (ready_o === 1'b1 || lat1 >= 100) break;
    end
    exp = sb.pop_front();
    n_vec++;
    if (ready_o !== 1'b1 || result_o !== exp || lat1 !== 33) begin
      n_err++; $display("FAIL b2b_first: got %h lat %0d want %h lat 33", result_o, lat1, exp);
    end
    // start stays high; new operands are picked up in the FREE cycle after END
    signed_div_i = 1'b1; opdata1_i = -32'sd100; opdata2_i = 32'd7;
    lat2 = 0;
    while (1) begin
      @(posedge clk); lat2++; @(negedge clk);
      if (ready_o === 1'b1 || lat2 >= 100) break;
    end
    exp = sb.pop_front();
    n_vec++;
    if (ready_o !== 1'b1 || result_o !== exp) begin
      n_err++; $display("FAIL b2b_second: got %h want %h", result_o, exp);
    end
    n_vec++;
    if (lat2 !== 34) begin n_err++; $display("FAIL b2b_spacing: got %0d want 34", lat2); end
    start_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_known();
    test_random();
    test_zero();
    test_abort();
    test_async_reset();
    test_back_to_back();
    n_vec++;
    if (sb.size() !== 0) begin n_err++; $display("FAIL scoreboard_empty: %0d left want 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_div
